// File: rtl/ram_fill_uart_dump.sv
// RAM fill-and-dump controller.
// key1 fills an internal single-port RAM with a selectable pattern.
// key2 streams the filled words out over an 8N1 UART, least significant byte first.
module ram_fill_uart_dump #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 256,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key1,
    input  logic              key2,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              rs232_tx,
    output logic              state_led,
    output logic              busy,
    output logic              tx_done
);

    localparam int RAW_DIV   = CLK_FREQ / BAUD;
    localparam int BAUD_DIV  = (RAW_DIV < 4) ? 4 : RAW_DIV;
    localparam int BC_W      = $clog2(BAUD_DIV);
    localparam int NUM_BYTES = DATA_W / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [BC_W-1:0]   LAST_BAUD = BC_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_RD   = 3'd2,
        S_LOAD = 3'd3,
        S_TX   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t              state_r;
    logic [1:0]          key1_sync_r;
    logic [1:0]          key2_sync_r;
    logic                key1_prev_r;
    logic                key2_prev_r;
    logic                fill_req_r;
    logic                dump_req_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   seed_r;
    logic [DATA_W-1:0]   word_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [3:0]          bit_cnt_r;
    logic [BC_W-1:0]     baud_cnt_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic [DATA_W-1:0]   mem_r [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   addr_word_s;
    logic [DATA_W-1:0]   fill_data_s;

    // Zero-extend or truncate an address to the word width.
    function automatic logic [DATA_W-1:0] addr_to_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] ext;
        ext = {{DATA_W{1'b0}}, a};
        return ext[DATA_W-1:0];
    endfunction

    // Synchronise the keys and turn their rising edges into registered 1-cycle requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key1_sync_r <= 2'b00;
            key2_sync_r <= 2'b00;
            key1_prev_r <= 1'b0;
            key2_prev_r <= 1'b0;
            fill_req_r  <= 1'b0;
            dump_req_r  <= 1'b0;
        end else begin
            key1_sync_r <= {key1_sync_r[0], key1};
            key2_sync_r <= {key2_sync_r[0], key2};
            key1_prev_r <= key1_sync_r[1];
            key2_prev_r <= key2_sync_r[1];
            fill_req_r  <= key1_sync_r[1] & ~key1_prev_r;
            dump_req_r  <= key2_sync_r[1] & ~key2_prev_r;
        end
    end

    // Fill pattern for the current address, selected by the mode latched at fill start.
    always_comb begin
        addr_word_s = addr_to_word(addr_r);
        fill_data_s = addr_word_s;
        case (mode_r)
            2'b00:   fill_data_s = addr_word_s;
            2'b01:   fill_data_s = ~addr_word_s;
            2'b10:   fill_data_s = seed_r;
            2'b11:   fill_data_s = seed_r + addr_word_s;
            default: fill_data_s = addr_word_s;
        endcase
    end

    // Single-port RAM: write during FILL, registered read every cycle (contents survive reset).
    always_ff @(posedge clk) begin
        if (state_r == S_FILL) begin
            mem_r[addr_r] <= fill_data_s;
        end
        rd_data_r <= mem_r[addr_r];
    end

    // Main control FSM with registered UART line and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            addr_r     <= '0;
            mode_r     <= 2'b00;
            seed_r     <= '0;
            word_r     <= '0;
            byte_idx_r <= '0;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= '0;
            rs232_tx   <= 1'b1;
            state_led  <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (fill_req_r) begin
                        state_r   <= S_FILL;
                        mode_r    <= mode;
                        seed_r    <= seed;
                        addr_r    <= '0;
                        state_led <= 1'b0;
                        busy      <= 1'b1;
                    end else if (dump_req_r && state_led) begin
                        state_r <= S_RD;
                        addr_r  <= '0;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (addr_r == LAST_ADDR) begin
                        state_r   <= S_IDLE;
                        addr_r    <= '0;
                        state_led <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end
                S_RD: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    // The start bit of the first byte goes out on the same edge the word is latched.
                    word_r     <= rd_data_r;
                    byte_idx_r <= '0;
                    bit_cnt_r  <= 4'd0;
                    baud_cnt_r <= '0;
                    rs232_tx   <= 1'b0;
                    state_r    <= S_TX;
                end
                S_TX: begin
                    if (baud_cnt_r != LAST_BAUD) begin
                        baud_cnt_r <= baud_cnt_r + BC_W'(1);
                    end else begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r < 4'd8) begin
                            // Shifting one bit per data bit leaves the next byte in the low bits.
                            rs232_tx  <= word_r[0];
                            word_r    <= word_r >> 1;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (bit_cnt_r == 4'd8) begin
                            rs232_tx  <= 1'b1;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else begin
                            bit_cnt_r <= 4'd0;
                            if (byte_idx_r != LAST_IDX) begin
                                byte_idx_r <= byte_idx_r + IDX_W'(1);
                                rs232_tx   <= 1'b0;
                            end else if (addr_r != LAST_ADDR) begin
                                addr_r  <= addr_r + ADDR_W'(1);
                                state_r <= S_RD;
                            end else begin
                                state_r <= S_FIN;
                                tx_done <= 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy     <= 1'b0;
                    rs232_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fill_uart_dump.sv
// Directed bench for ram_fill_uart_dump: an 8-bit and a 16-bit instance, UART decoders,
// and one task per scenario with hand-computed expectations.
module tb_ram_fill_uart_dump;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic key1_8 = 1'b0, key2_8 = 1'b0, key1_16 = 1'b0, key2_16 = 1'b0;
    logic [1:0]  mode8 = 2'b00, mode16 = 2'b00;
    logic [7:0]  seed8 = 8'h00;
    logic [15:0] seed16 = 16'h0000;
    logic tx8, led8, busy8, done8, tx16, led16, busy16, done16;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] q8[$];
    logic [7:0] q16[$];
    int st16[$];

    ram_fill_uart_dump #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .ADDR_W(8), .NUM_WORDS(4), .DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .key1(key1_8), .key2(key2_8), .mode(mode8), .seed(seed8),
        .rs232_tx(tx8), .state_led(led8), .busy(busy8), .tx_done(done8));

    ram_fill_uart_dump #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .ADDR_W(8), .NUM_WORDS(4), .DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .key1(key1_16), .key2(key2_16), .mode(mode16), .seed(seed16),
        .rs232_tx(tx16), .state_led(led16), .busy(busy16), .tx_done(done16));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: detects a falling edge, samples mid-bit, queues bytes and frame start cycles.
    task automatic uart_rx(input bit sel);
        logic prev, cur;
        logic [7:0] b;
        int t0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = sel ? tx16 : tx8;
            if (rst_n && prev && !cur) begin
                t0 = cyc;
                repeat (DIV/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = sel ? tx16 : tx8;
                end
                repeat (DIV) @(negedge clk);
                if (sel) begin q16.push_back(b); st16.push_back(t0); end
                else q8.push_back(b);
                cur = sel ? tx16 : tx8;
            end
            prev = cur;
        end
    endtask

    initial uart_rx(1'b0);
    initial uart_rx(1'b1);

    // Pulse key1 (optionally key2 too) and measure when busy rises and state_led comes back.
    task automatic run_fill(input bit wide, input bit with_key2, output int busy_at, output int led_at, output logic led_clr);
        @(posedge clk); #1;
        if (wide) key1_16 = 1'b1;
        else begin key1_8 = 1'b1; if (with_key2) key2_8 = 1'b1; end
        busy_at = 0; led_at = 0; led_clr = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin key1_8 = 1'b0; key2_8 = 1'b0; key1_16 = 1'b0; end
            if (busy_at == 0 && (wide ? busy16 : busy8)) begin busy_at = n; led_clr = wide ? led16 : led8; end
            if (busy_at != 0 && n > busy_at && (wide ? led16 : led8)) begin led_at = n; break; end
        end
    endtask

    // Pulse key2 and follow the dump to completion (bounded); optionally press key1 mid-dump.
    task automatic run_dump(input bit wide, input int inject_at, output int busy_at, output int done_at,
                            output int done_cnt, output int idle_at);
        logic b, d;
        @(posedge clk); #1;
        if (wide) key2_16 = 1'b1; else key2_8 = 1'b1;
        busy_at = 0; done_at = 0; done_cnt = 0; idle_at = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin key2_8 = 1'b0; key2_16 = 1'b0; end
            if (n == inject_at) begin if (wide) key1_16 = 1'b1; else key1_8 = 1'b1; end
            if (n == inject_at + 3) begin key1_8 = 1'b0; key1_16 = 1'b0; end
            b = wide ? busy16 : busy8;
            d = wide ? done16 : done8;
            if (busy_at == 0 && b) busy_at = n;
            if (d) begin done_cnt++; if (done_at == 0) done_at = n; end
            if (done_at != 0 && !b) begin idle_at = n; break; end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx8 got %b want 1", tx8); end
        checks++; if (led8 !== 1'b0) begin errors++; $display("FAIL reset_led8 got %b want 0", led8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", done8); end
        checks++; if (tx16 !== 1'b1) begin errors++; $display("FAIL reset_tx16 got %b want 1", tx16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16 got %b want 0", busy16); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (led8 !== 1'b0) begin errors++; $display("FAIL post_reset_led8 got %b want 0", led8); end
    endtask

    task automatic test_dump_without_fill;
        @(posedge clk); #1;
        key2_8 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 10) key2_8 = 1'b0;
            checks++;
            if (busy8 !== 1'b0 || tx8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL nofill_idle cycle %0d got busy=%b tx=%b done=%b want 0 1 0", n, busy8, tx8, done8);
            end
        end
        checks++; if (q8.size() != 0) begin errors++; $display("FAIL nofill_bytes got %0d want 0", q8.size()); end
    endtask

    task automatic fill_dump8(input string name, input logic [1:0] m, input logic [7:0] s, input logic [31:0] exp);
        int busy_at, led_at, done_at, done_cnt, idle_at;
        logic led_clr;
        logic [7:0] got, want;
        mode8 = m; seed8 = s;
        run_fill(1'b0, 1'b0, busy_at, led_at, led_clr);
        checks++; if (busy_at != 4) begin errors++; $display("FAIL %s fill_busy_at got %0d want 4", name, busy_at); end
        checks++; if (led_at != 8) begin errors++; $display("FAIL %s led_rise_at got %0d want 8", name, led_at); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL %s busy_after_fill got %b want 0", name, busy8); end
        q8.delete();
        run_dump(1'b0, 0, busy_at, done_at, done_cnt, idle_at);
        checks++; if (busy_at != 4) begin errors++; $display("FAIL %s dump_busy_at got %0d want 4", name, busy_at); end
        checks++; if (done_at != 412) begin errors++; $display("FAIL %s tx_done_at got %0d want 412", name, done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s tx_done_pulses got %0d want 1", name, done_cnt); end
        checks++; if (idle_at != 413) begin errors++; $display("FAIL %s busy_fall_at got %0d want 413", name, idle_at); end
        checks++; if (q8.size() != 4) begin errors++; $display("FAIL %s byte_count got %0d want 4", name, q8.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < q8.size()) ? q8[i] : 8'hxx;
            want = exp[8*i +: 8];
            checks++; if (got !== want) begin errors++; $display("FAIL %s byte%0d got %h want %h", name, i, got, want); end
        end
    endtask

    task automatic test_fill_mode0;
        fill_dump8("mode0", 2'b00, 8'h00, 32'h03020100);
    endtask

    task automatic test_wrap;
        fill_dump8("wrap", 2'b11, 8'hFE, 32'h0100FFFE);
    endtask

    task automatic test_wide;
        int busy_at, led_at, done_at, done_cnt, idle_at, gap;
        logic led_clr;
        logic [7:0] exp [8];
        logic [7:0] got;
        exp = '{8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFD, 8'hFF, 8'hFC, 8'hFF};
        mode16 = 2'b01; seed16 = 16'h1234;
        run_fill(1'b1, 1'b0, busy_at, led_at, led_clr);
        checks++; if (led_at != 8) begin errors++; $display("FAIL wide led_rise_at got %0d want 8", led_at); end
        q16.delete(); st16.delete();
        run_dump(1'b1, 0, busy_at, done_at, done_cnt, idle_at);
        checks++; if (done_at != 812) begin errors++; $display("FAIL wide tx_done_at got %0d want 812", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wide tx_done_pulses got %0d want 1", done_cnt); end
        checks++; if (q16.size() != 8) begin errors++; $display("FAIL wide byte_count got %0d want 8", q16.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < q16.size()) ? q16[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL wide byte%0d got %h want %h", i, got, exp[i]); end
        end
        for (int i = 1; i < 8; i++) begin
            gap = (i < st16.size()) ? st16[i] - st16[i-1] : -1;
            checks++;
            if (gap != ((i % 2 == 1) ? 100 : 102)) begin
                errors++; $display("FAIL wide frame_gap%0d got %0d want %0d", i, gap, (i % 2 == 1) ? 100 : 102);
            end
        end
    endtask

    task automatic test_simultaneous;
        int busy_at, led_at;
        logic led_clr;
        mode8 = 2'b10; seed8 = 8'h5A;
        q8.delete();
        run_fill(1'b0, 1'b1, busy_at, led_at, led_clr);
        checks++; if (busy_at != 4) begin errors++; $display("FAIL simul busy_at got %0d want 4", busy_at); end
        checks++; if (led_clr !== 1'b0) begin errors++; $display("FAIL simul led_cleared got %b want 0", led_clr); end
        checks++; if (led_at != 8) begin errors++; $display("FAIL simul led_rise_at got %0d want 8", led_at); end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL simul no_dump cycle %0d busy got %b want 0", n, busy8); end
        end
        checks++; if (q8.size() != 0) begin errors++; $display("FAIL simul bytes got %0d want 0", q8.size()); end
    endtask

    task automatic test_key1_during_dump;
        int busy_at, done_at, done_cnt, idle_at;
        logic [7:0] got;
        q8.delete();
        run_dump(1'b0, 100, busy_at, done_at, done_cnt, idle_at);
        checks++; if (done_at != 412) begin errors++; $display("FAIL busykey tx_done_at got %0d want 412", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busykey tx_done_pulses got %0d want 1", done_cnt); end
        checks++; if (q8.size() != 4) begin errors++; $display("FAIL busykey byte_count got %0d want 4", q8.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < q8.size()) ? q8[i] : 8'hxx;
            checks++; if (got !== 8'h5A) begin errors++; $display("FAIL busykey byte%0d got %h want 5a", i, got); end
        end
        repeat (10) @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0 || led8 !== 1'b1) begin errors++; $display("FAIL busykey after got busy=%b led=%b want 0 1", busy8, led8); end
    endtask

    task automatic test_reset_mid_frame;
        int busy_at, led_at, done_at, done_cnt, idle_at;
        logic led_clr;
        mode8 = 2'b00; seed8 = 8'h00;
        run_fill(1'b0, 1'b0, busy_at, led_at, led_clr);
        q8.delete();
        @(posedge clk); #1;
        key2_8 = 1'b1;
        for (int n = 1; n <= 213; n++) begin
            @(posedge clk); #1;
            if (n == 3) key2_8 = 1'b0;
        end
        checks++; if (tx8 !== 1'b0) begin errors++; $display("FAIL midframe start_bit got %b want 0", tx8); end
        checks++; if (q8.size() != 2) begin errors++; $display("FAIL midframe bytes_before got %0d want 2", q8.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL midframe async_tx got %b want 1", tx8); end
        checks++; if (led8 !== 1'b0) begin errors++; $display("FAIL midframe async_led got %b want 0", led8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midframe async_busy got %b want 0", busy8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (120) @(posedge clk);
        q8.delete();
        run_dump(1'b0, 0, busy_at, done_at, done_cnt, idle_at);
        checks++; if (busy_at != 0) begin errors++; $display("FAIL midframe later_dump_busy got %0d want 0", busy_at); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midframe later_dump_done got %0d want 0", done_cnt); end
        checks++; if (q8.size() != 0 || tx8 !== 1'b1) begin errors++; $display("FAIL midframe later_dump_tx got bytes=%0d tx=%b want 0 1", q8.size(), tx8); end
    endtask

    initial begin
        test_reset();
        test_dump_without_fill();
        test_fill_mode0();
        test_wrap();
        test_wide();
        test_simultaneous();
        test_key1_during_dump();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
